fp8_add_pipe: RTL and testbench
===============================

# fp8_add_pipe

Parametrised, pipelined floating-point adder/subtractor for the FP8 datapath, successor to the combinational E4M3 adder. Supports any small sign/exponent/mantissa split (E4M3, E5M2, …), round-to-nearest-even, subnormals and saturation, and sits between operand fetch and the log-domain accumulate stage. It uses a three-stage valid/ready pipeline and carries a sideband tag alongside each operation.

## Interface
- EXP_W, 4, exponent field width; bias = 2^(EXP_W-1)-1
- MAN_W, 3, stored mantissa width (hidden bit not stored)
- TAG_W, 4, sideband tag width, passed through unchanged
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  operands and op valid
- in_ready  out  1  block accepts the current input this cycle
- in_a, in_b  in  1+EXP_W+MAN_W  operands {sign, exp, man}
- in_op  in  1  0 = A+B, 1 = A−B (B sign inverted at input)
- in_tag  in  TAG_W  sideband ID
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  1+EXP_W+MAN_W  rounded result
- out_tag  out  TAG_W  tag of the result
- out_flags  out  3  {overflow, underflow, inexact}; present only with FP8_ADD_FLAGS_EN

## Operation
- Encoding: every code is finite; there is no inf/NaN. Exponent 0 is subnormal: hidden bit 0, scale of exponent 1. The all-ones exponent is a normal value.
- S1, align:
  - Swap so that |X| ≥ |Y|, comparing {exp, man}.
  - Result sign = sign of X.
  - Shift Y's significand right by the exponent difference into a MAN_W+1 field plus guard, round and sticky bits.
  - A shift ≥ MAN_W+3 leaves only sticky.
- S2, add:
  - Same signs: add. Different signs: subtract.
  - Sum width MAN_W+5: carry, hidden, mantissa, G, R, S.
  - Leading-zero count computed on the sum.
- S3, normalise and round:
  - Carry out: shift right 1, exponent +1, and OR the shifted-out bit into sticky.
  - Otherwise shift left by min(lzc, exp−1). If the hidden bit is still 0, the result is subnormal with exponent field 0.
  - Round to nearest even from G, R, S. A mantissa carry after rounding increments the exponent.
- Overflow: exponent exceeds 2^EXP_W−1. Saturate to the max-magnitude code with the result sign and set overflow.
- Exact zero result:
  - +0, except (−0)+(−0), which gives −0.
  - Exact cancellation gives +0.
- Flags (with FP8_ADD_FLAGS_EN):
  - inexact = any G/R/S bit was nonzero, or saturation occurred.
  - underflow = result is subnormal or zero and inexact.

## Timing
- Latency: 3 cycles from the accept edge to out_valid when there is no stall.
- Throughput: 1 per cycle.
- Accept occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Global stall:
  - advance = out_ready || !out_valid; in_ready = advance.
  - All stage registers and valids hold when advance = 0. Bubbles are not collapsed.
- Stable output: out_data, out_tag and out_flags stay stable while out_valid && !out_ready.
- Same-cycle transfer: an output transfer and an input accept in the same cycle are both honoured.
- Reset: all stage valids = 0, out_valid = 0, out_data = 0, out_tag = 0, out_flags = 0, in_ready = 1.
- Reset mid-operation: in-flight operations are discarded with no output. The first accept after rst_n deasserts is the first result.

## Configuration
- FP8_ADD_FLAGS_EN defined:
  - out_flags port exists.
  - A 3-bit flag field is pipelined through S2 and S3 and held with the result.
- Not defined:
  - out_flags port and flag registers are absent.
  - Saturation and rounding behaviour is unchanged.

## Test plan
- E4M3 basics: 0x38+0x38 (1.0+1.0) -> 0x40 after 3 cycles. 0x38 with in_op=1 and 0x38 -> 0x00 (+0). 0xB8+0xB8 -> 0xC0.
- Round-to-even: 0x38+0x18 (1.0+0.0625, tie) -> 0x38 with inexact=1. 0x39+0x18 (1.125+0.0625, tie) -> 0x3A.
- Saturation and subnormals: 0x7F+0x7F -> 0x7F with overflow=1. 0xFF+0xFF -> 0xFF. 0x01+0x01 -> 0x02 with no flags. 0x08 with in_op=1 and 0x01 -> 0x07.
- Backpressure: out_ready low for 5 cycles with in_valid high. Exactly 3 ops accepted, then in_ready=0. On release, results emerge in order with tags 0,1,2 and data stable during the stall.
- Streaming: 100 random back-to-back ops with random out_ready. Every result matches the golden model bit-exactly (E4M3 and E5M2 builds), with no drops or duplicates.
- Reset: assert rst_n low while 2 ops are in flight -> out_valid=0 immediately. After deassert, only new ops appear.

Source files
------------

// File: rtl/fp8_add_pipe.sv
// Purpose : pipelined small-float adder/subtractor (sign/exp/man, RNE, subnormals, saturation), tag passed through.
// Latency : 3 register stages; out_valid rises on the third rising edge counting the accept edge.
// Backpressure: global stall, in_ready = out_ready || !out_valid; all stages hold. FP8_ADD_FLAGS_EN adds out_flags.
module fp8_add_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_op,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_data,
  output logic [TAG_W-1:0]     out_tag
`ifdef FP8_ADD_FLAGS_EN
  ,
  output logic [2:0]           out_flags
`endif
);
  localparam int DW  = 1 + EXP_W + MAN_W;  // code width
  localparam int SW  = MAN_W + 4;          // hidden + mantissa + G/R/S
  localparam int NW  = MAN_W + 5;          // sum incl. carry
  localparam int EW  = EXP_W + 1;          // exponent with overflow headroom
  localparam int RW  = MAN_W + 2;          // rounded significand incl. carry
  localparam int SHW = $clog2(SW + 1);

  logic w_adv;

  // ---------------- S1: swap and align ----------------
  logic [DW-2:0]    w_a_mag, w_b_mag, w_x_mag, w_y_mag;
  logic             w_b_sgn, w_swap, w_x_sgn, w_y_sgn;
  logic [EXP_W-1:0] w_x_exp, w_y_exp, w_x_ee, w_y_ee, w_diff;
  logic [MAN_W:0]   w_x_sig, w_y_sig;
  logic [SHW-1:0]   w_sh;
  logic [2*SW-1:0]  w_y_wide;
  logic [SW-1:0]    w_y_al;

  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  assign w_a_mag = in_a[DW-2:0];
  assign w_b_mag = in_b[DW-2:0];
  assign w_b_sgn = in_b[DW-1] ^ in_op;
  assign w_swap  = (w_b_mag > w_a_mag);
  assign w_x_mag = w_swap ? w_b_mag : w_a_mag;
  assign w_y_mag = w_swap ? w_a_mag : w_b_mag;
  assign w_x_sgn = w_swap ? w_b_sgn : in_a[DW-1];
  assign w_y_sgn = w_swap ? in_a[DW-1] : w_b_sgn;
  assign w_x_exp = w_x_mag[DW-2:MAN_W];
  assign w_y_exp = w_y_mag[DW-2:MAN_W];
  // subnormals share the scale of exponent 1
  assign w_x_ee  = (w_x_exp == '0) ? EXP_W'(1) : w_x_exp;
  assign w_y_ee  = (w_y_exp == '0) ? EXP_W'(1) : w_y_exp;
  assign w_x_sig = {|w_x_exp, w_x_mag[MAN_W-1:0]};
  assign w_y_sig = {|w_y_exp, w_y_mag[MAN_W-1:0]};
  assign w_diff  = w_x_ee - w_y_ee;
  // beyond SW every bit of Y has already fallen into sticky
  assign w_sh    = (int'(w_diff) > SW) ? SHW'(SW) : SHW'(w_diff);
  assign w_y_wide = {w_y_sig, 3'b000, {SW{1'b0}}} >> w_sh;
  assign w_y_al  = w_y_wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |w_y_wide[SW-1:0]};

  logic             r_s1_vld, r_s1_sgn, r_s1_sub;
  logic [EXP_W-1:0] r_s1_exp;
  logic [SW-1:0]    r_s1_x, r_s1_y;
  logic [TAG_W-1:0] r_s1_tag;

  // S1 register: larger operand, aligned smaller operand, effective operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0; r_s1_sgn <= 1'b0; r_s1_sub <= 1'b0;
      r_s1_exp <= '0;   r_s1_x   <= '0;   r_s1_y   <= '0; r_s1_tag <= '0;
    end else if (w_adv) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_sgn <= w_x_sgn;
        r_s1_sub <= w_x_sgn ^ w_y_sgn;
        r_s1_exp <= w_x_ee;
        r_s1_x   <= {w_x_sig, 3'b000};
        r_s1_y   <= w_y_al;
        r_s1_tag <= in_tag;
      end
    end
  end

  // ---------------- S2: add/subtract and leading-zero count ----------------
  logic [NW-1:0]  w_sum;
  logic [SHW-1:0] w_lzc;
  logic           w_s2_sgn;

  assign w_sum = r_s1_sub ? ({1'b0, r_s1_x} - {1'b0, r_s1_y}) : ({1'b0, r_s1_x} + {1'b0, r_s1_y});
  // a zero sum is -0 only when both inputs were same-signed negative zeros
  assign w_s2_sgn = (w_sum == '0) ? (r_s1_sgn & ~r_s1_sub) : r_s1_sgn;

  // leading zeros below the carry bit; the highest set bit wins
  always_comb begin
    w_lzc = SHW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (w_sum[i]) w_lzc = SHW'(SW - 1 - i);
    end
  end

  logic             r_s2_vld, r_s2_sgn;
  logic [EXP_W-1:0] r_s2_exp;
  logic [NW-1:0]    r_s2_sum;
  logic [SHW-1:0]   r_s2_lzc;
  logic [TAG_W-1:0] r_s2_tag;

  // S2 register: raw sum, its normalisation distance and the final sign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld <= 1'b0; r_s2_sgn <= 1'b0; r_s2_exp <= '0;
      r_s2_sum <= '0;   r_s2_lzc <= '0;   r_s2_tag <= '0;
    end else if (w_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_sgn <= w_s2_sgn;
        r_s2_exp <= r_s1_exp;
        r_s2_sum <= w_sum;
        r_s2_lzc <= w_lzc;
        r_s2_tag <= r_s1_tag;
      end
    end
  end

  // ---------------- S3: normalise, round, saturate ----------------
  logic [EXP_W-1:0] w_lim;
  logic [SHW-1:0]   w_ls;
  logic [SW-1:0]    w_norm;
  logic [EW-1:0]    w_en, w_ef;
  logic             w_up, w_ovf;
  logic [RW-1:0]    w_rsig;
  logic [MAN_W-1:0] w_mf;
  logic [DW-1:0]    w_res;

  // normalise (left shift stops at exponent 1), round to nearest even, saturate
  always_comb begin
    w_lim = r_s2_exp - EXP_W'(1);
    w_ls  = (int'(r_s2_lzc) <= int'(w_lim)) ? r_s2_lzc : SHW'(w_lim);
    if (r_s2_sum[NW-1]) begin
      w_norm = {r_s2_sum[NW-1:2], |r_s2_sum[1:0]};
      w_en   = {1'b0, r_s2_exp} + EW'(1);
    end else begin
      w_norm = r_s2_sum[SW-1:0] << w_ls;
      w_en   = {1'b0, r_s2_exp} - EW'(w_ls);
    end
    w_up   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rsig = {1'b0, w_norm[SW-1:3]} + RW'(w_up);
    if (w_rsig[RW-1]) begin
      w_ef = w_en + EW'(1);
      w_mf = '0;
    end else if (w_rsig[MAN_W]) begin
      w_ef = w_en;
      w_mf = w_rsig[MAN_W-1:0];
    end else begin
      w_ef = '0;
      w_mf = w_rsig[MAN_W-1:0];
    end
    w_ovf = w_ef[EW-1];
    w_res = w_ovf ? {r_s2_sgn, {(DW-1){1'b1}}} : {r_s2_sgn, w_ef[EXP_W-1:0], w_mf};
  end

`ifdef FP8_ADD_FLAGS_EN
  logic       w_inx, w_unf;
  logic [2:0] r_s3_flags;
  assign w_inx     = (|w_norm[2:0]) | w_ovf;
  assign w_unf     = (w_ef == '0) & w_inx;
  assign out_flags = r_s3_flags;
`endif

  logic             r_s3_vld;
  logic [DW-1:0]    r_s3_dat;
  logic [TAG_W-1:0] r_s3_tag;

  // S3/output register: holds the result until downstream takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_vld <= 1'b0; r_s3_dat <= '0; r_s3_tag <= '0;
`ifdef FP8_ADD_FLAGS_EN
      r_s3_flags <= '0;
`endif
    end else if (w_adv) begin
      r_s3_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_s3_dat <= w_res;
        r_s3_tag <= r_s2_tag;
`ifdef FP8_ADD_FLAGS_EN
        r_s3_flags <= {w_ovf, w_unf, w_inx};
`endif
      end
    end
  end

  assign out_valid = r_s3_vld;
  assign out_data  = r_s3_dat;
  assign out_tag   = r_s3_tag;

endmodule

// File: tb/tb_fp8_add_pipe.sv
// Directed + streamed checks of fp8_add_pipe in its E4M3 configuration.
// Expected values are hand-derived constants or an exact-arithmetic rounding model.
`timescale 1ns/1ps
module tb_fp8_add_pipe;
  localparam int EXP_W = 4;
  localparam int MAN_W = 3;
  localparam int TAG_W = 4;
  localparam int DW    = 1 + EXP_W + MAN_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_op = 1'b0;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    in_a = '0;
  logic [DW-1:0]    in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_ready, out_valid;
  logic [DW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;
`ifdef FP8_ADD_FLAGS_EN
  logic [2:0]       out_flags;
`endif

  fp8_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
`ifdef FP8_ADD_FLAGS_EN
    , .out_flags(out_flags)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct packed {
    logic [2:0]       f;
    logic [DW-1:0]    d;
    logic [TAG_W-1:0] t;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, expv);
  endtask

  // value of a code in units of the smallest subnormal step
  function automatic longint mag_of(input logic [DW-1:0] c);
    int e;
    longint m;
    e = int'(c[DW-2:MAN_W]);
    m = longint'(c[MAN_W-1:0]);
    if (e == 0) return m;
    return ((longint'(1) << MAN_W) + m) << (e - 1);
  endfunction

  // exact sum, then RNE into the format; returns {ovf, unf, inexact, code}
  function automatic logic [DW+2:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op);
    logic sa, sb, sr, inx, ovf, unf;
    longint sum, mag, ulp, q, rem, half;
    int e;
    logic [EXP_W-1:0] ef;
    logic [MAN_W-1:0] mf;
    sa  = a[DW-1];
    sb  = b[DW-1] ^ op;
    sum = (sa ? -mag_of(a) : mag_of(a)) + (sb ? -mag_of(b) : mag_of(b));
    sr  = (sum < 0);
    mag = sr ? -sum : sum;
    inx = 1'b0; ovf = 1'b0;
    if (mag == 0) begin
      sr = sa & sb; ef = '0; mf = '0;
    end else if (mag < (longint'(1) << MAN_W)) begin
      ef = '0; mf = mag[MAN_W-1:0];
    end else begin
      e = 1;
      while (mag >= (longint'(1) << (MAN_W + e))) e++;
      ulp  = longint'(1) << (e - 1);
      q    = mag >> (e - 1);
      rem  = mag & (ulp - 1);
      half = ulp >> 1;
      if (rem != 0) inx = 1'b1;
      if (rem > half || (rem == half && rem != 0 && q[0])) q++;
      if (q == (longint'(1) << (MAN_W + 1))) begin q = q >> 1; e++; end
      if (e > (1 << EXP_W) - 1) begin
        ovf = 1'b1; inx = 1'b1; ef = '1; mf = '1;
      end else begin
        ef = e[EXP_W-1:0]; mf = q[MAN_W-1:0];
      end
    end
    unf = (ef == '0) & inx;
    return {ovf, unf, inx, sr, ef, mf};
  endfunction

  // one isolated op: accept, exact latency, data, tag (and flags)
  task automatic single(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op,
                        input logic [TAG_W-1:0] tg, input logic [DW-1:0] expd,
                        input logic [2:0] expf, input string nm);
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tg; out_ready = 1'b1;
    @(negedge clk);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;       // accept edge
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, ".early_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".data"}, 32'(out_data), 32'(expd));
    chk({nm, ".tag"}, 32'(out_tag), 32'(tg));
`ifdef FP8_ADD_FLAGS_EN
    chk({nm, ".flags"}, 32'(out_flags), 32'(expf));
`endif
  endtask

  logic [DW-1:0]    bpa [4];
  logic [DW-1:0]    bpb [4];
  logic [DW+2:0]    m;
  logic [DW-1:0]    hold_d;
  logic [TAG_W-1:0] hold_t;
  logic             have, ai, stalled, acc_now;
  int               acc, got, vcnt, sent, rcvd;
  exp_t             q [$];
  exp_t             e_front;

  initial begin
    // ---------------- reset state ----------------
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_tag", 32'(out_tag), 32'd0);
`ifdef FP8_ADD_FLAGS_EN
    chk("rst.out_flags", 32'(out_flags), 32'd0);
`endif
    rst_n = 1'b1;

    // ---------------- directed E4M3 vectors ----------------
    single(8'h38, 8'h38, 1'b0, 4'h1, 8'h40, 3'b000, "1p1");
    single(8'h38, 8'h38, 1'b1, 4'h2, 8'h00, 3'b000, "1m1");
    single(8'hB8, 8'hB8, 1'b0, 4'h3, 8'hC0, 3'b000, "n1pn1");
    single(8'h38, 8'h18, 1'b0, 4'h4, 8'h38, 3'b001, "rne_tie_even");
    single(8'h39, 8'h18, 1'b0, 4'h5, 8'h3A, 3'b001, "rne_tie_odd");
    single(8'h3F, 8'h18, 1'b0, 4'h6, 8'h40, 3'b001, "rne_exp_carry");
    single(8'h7F, 8'h7F, 1'b0, 4'h7, 8'h7F, 3'b101, "sat_pos");
    single(8'hFF, 8'hFF, 1'b0, 4'h8, 8'hFF, 3'b101, "sat_neg");
    single(8'h01, 8'h01, 1'b0, 4'h9, 8'h02, 3'b000, "sub_add");
    single(8'h08, 8'h01, 1'b1, 4'hA, 8'h07, 3'b000, "norm_to_sub");
    single(8'h01, 8'h02, 1'b1, 4'hB, 8'h81, 3'b000, "swap_neg_sub");
    single(8'h80, 8'h80, 1'b0, 4'hC, 8'h80, 3'b000, "nz_p_nz");
    single(8'h80, 8'h00, 1'b0, 4'hD, 8'h00, 3'b000, "nz_p_pz");
    single(8'h80, 8'h00, 1'b1, 4'hE, 8'h80, 3'b000, "nz_m_pz");
    single(8'hB8, 8'h38, 1'b0, 4'hF, 8'h00, 3'b000, "cancel");
    single(8'h78, 8'h01, 1'b0, 4'h0, 8'h78, 3'b001, "far_sticky");
    single(8'h40, 8'h01, 1'b1, 4'h1, 8'h40, 3'b001, "sub_sticky_round");

    // ---------------- backpressure: 5 stalled cycles ----------------
    bpa[0] = 8'h38; bpb[0] = 8'h38;
    bpa[1] = 8'h39; bpb[1] = 8'h18;
    bpa[2] = 8'h01; bpb[2] = 8'h01;
    bpa[3] = 8'h7F; bpb[3] = 8'h7F;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_op = 1'b0;
    in_a = bpa[0]; in_b = bpb[0]; in_tag = '0;
    acc = 0; have = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (have) begin
        chk("bp.hold_data", 32'(out_data), 32'(hold_d));
        chk("bp.hold_tag", 32'(out_tag), 32'(hold_t));
      end
      if (out_valid) begin have = 1'b1; hold_d = out_data; hold_t = out_tag; end
      ai = in_valid & in_ready;
      @(posedge clk); #1;
      if (ai) begin
        acc++;
        in_a = bpa[acc]; in_b = bpb[acc]; in_tag = TAG_W'(acc);
      end
    end
    @(negedge clk);
    chk("bp.accepted", 32'(acc), 32'd3);
    chk("bp.in_ready_low", 32'(in_ready), 32'd0);
    chk("bp.out_valid", 32'(out_valid), 32'd1);
    chk("bp.hold_data_end", 32'(out_data), 32'(hold_d));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        m = model(bpa[got], bpb[got], 1'b0);
        chk("bp.order_tag", 32'(out_tag), 32'(got));
        chk("bp.order_data", 32'(out_data), 32'(m[DW-1:0]));
        got++;
      end
    end
    chk("bp.results", 32'(got), 32'd3);
    @(negedge clk);
    chk("bp.drained", 32'(out_valid), 32'd0);

    // ---------------- reset with ops in flight ----------------
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'h38; in_b = 8'h38; in_op = 1'b0; in_tag = 4'h5; out_ready = 1'b1;
    @(posedge clk); #1;
    in_tag = 4'h6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid.out_tag", 32'(out_tag), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("rst_mid.no_stale", 32'(vcnt), 32'd0);
    single(8'h48, 8'h38, 1'b0, 4'h9, 8'h4A, 3'b000, "post_rst");

    // ---------------- streaming 100 random ops, random out_ready ----------------
    @(posedge clk); #1;
    sent = 0; rcvd = 0; stalled = 1'b0; hold_d = '0; hold_t = '0;
    in_valid = 1'b1; in_a = DW'($urandom); in_b = DW'($urandom); in_op = 1'($urandom);
    in_tag = '0; out_ready = 1'b1;
    for (int c = 0; c < 3000 && rcvd < 100; c++) begin
      @(negedge clk);
      if (stalled) begin
        chk("st.stable_data", 32'(out_data), 32'(hold_d));
        chk("st.stable_tag", 32'(out_tag), 32'(hold_t));
      end
      acc_now = in_valid & in_ready;
      if (acc_now) begin
        m = model(in_a, in_b, in_op);
        q.push_back('{f: m[DW+2:DW], d: m[DW-1:0], t: in_tag});
        sent++;
      end
      if (out_valid && out_ready) begin
        chk("st.expected_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e_front = q.pop_front();
          chk("st.data", 32'(out_data), 32'(e_front.d));
          chk("st.tag", 32'(out_tag), 32'(e_front.t));
`ifdef FP8_ADD_FLAGS_EN
          chk("st.flags", 32'(out_flags), 32'(e_front.f));
`endif
        end
        rcvd++;
      end
      stalled = out_valid & ~out_ready;
      hold_d  = out_data;
      hold_t  = out_tag;
      @(posedge clk); #1;
      if (acc_now) begin
        if (sent < 100) begin
          in_a = DW'($urandom); in_b = DW'($urandom); in_op = 1'($urandom);
          in_tag = TAG_W'(sent);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("st.sent", 32'(sent), 32'd100);
    chk("st.received", 32'(rcvd), 32'd100);
    chk("st.queue_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
